cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss handler that sits directly upstream of the multi-cycle, 16-bit, byte-addressed main memory (memory4c), which has a 4-cycle read latency.
- On a cache miss it issues one read per cycle for every word of the 16-byte block.
- It collects the returned words in order, writes each into the cache data array, then writes the tag array on the last word.
- The pipelined memory lets all 8 requests overlap, so a fill takes 12 busy cycles rather than 32.

Parameters:
- ADDR_WIDTH, 16, byte-address width; must match the memory.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.
- OFFSET_BITS, 4, byte-offset bits; equals log2(WORDS_PER_BLOCK*2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
- miss_address  in  ADDR_WIDTH  byte address of the missing access.
- fsm_busy  out  1  fill in progress; the cache stalls the pipeline while this is high.
- mem_enable  out  1  memory enable (read request).
- mem_wr  out  1  memory write strobe; tied 0, this block only reads.
- mem_addr  out  ADDR_WIDTH  memory byte address; bit 0 is always 0.
- mem_data_valid  in  1  memory read-data valid.
- mem_data_out  in  16  memory read data.
- write_data_array  out  1  write one word into the cache data array.
- write_word_offset  out  log2(WORDS_PER_BLOCK)  word index within the block for that write.
- write_data  out  16  data for the array write; equals mem_data_out.
- write_tag_array  out  1  write the tag/valid entry for the block.
- fill_block_addr  out  ADDR_WIDTH  base of the block being filled (low OFFSET_BITS = 0).

Behaviour:
- Reset (synchronous, active-high): state=IDLE, issue_cnt=0, ret_cnt=0, fill_block_addr=0.
  - All outputs are 0 during and after reset.
  - Reset mid-fill aborts immediately; no tag write occurs. The memory's read pipeline is cleared by the same rst, so no stale valids return afterwards.
- States: IDLE, FILL. There is no DONE state.
- IDLE:
  - fsm_busy=0, mem_enable=0.
  - If miss_detected at a posedge: latch fill_block_addr = miss_address with low OFFSET_BITS cleared; record start_word = miss_address[OFFSET_BITS-1:1]; move to FILL.
  - mem_data_valid in IDLE is ignored.
- FILL, request side:
  - fsm_busy=1.
  - While issue_cnt < WORDS_PER_BLOCK: mem_enable=1, mem_addr = fill_block_addr | (word_idx(issue_cnt) << 1), issue_cnt increments each cycle.
  - Requests are issued back-to-back with no gaps; after the last request mem_enable=0.
- FILL, return side:
  - Each cycle with mem_data_valid=1: write_data_array=1, write_word_offset=word_idx(ret_cnt), write_data=mem_data_out; ret_cnt increments.
  - Words are assumed to return in issue order.
- Last word (ret_cnt == WORDS_PER_BLOCK-1 with valid):
  - write_tag_array=1 in the same cycle.
  - The next state is IDLE, with counters cleared.
  - fsm_busy drops the cycle after the tag write.
- Timing: miss sampled at edge 0 → requests in cycles 1–8 → data in cycles 5–12 → tag write in cycle 12 → fsm_busy=0 in cycle 13. A new miss may be accepted in cycle 13.
- miss_detected while in FILL is ignored. The cache re-presents the access once fsm_busy drops.
- Address arithmetic:
  - The word index wraps modulo WORDS_PER_BLOCK and never carries into the tag bits.
  - Counters are log2(WORDS_PER_BLOCK)+1 bits so that the "all issued" condition is distinguishable.
- word_idx(n) = n in the default build.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: word_idx(n) = (start_word + n) mod WORDS_PER_BLOCK, so the missed word is fetched and written first.
  - Additional output crit_word_ready (1 bit) pulses in the cycle that word is written, letting the pipeline restart early. It is 0 on reset.
- Undefined: word_idx(n) = n, fetch starts at word 0, and the crit_word_ready port does not exist.

Decomposition:
- Package cache_pkg: WORDS_PER_BLOCK, OFFSET_BITS, WORD_IDX_BITS, and the fill_state_t enum {IDLE, FILL}.
- One sub-module, cache_word_counter: a synchronous clear/increment counter with terminal flag.
  - Instantiated twice, once for issue_cnt and once for ret_cnt.

Test Plan:
1. Reset, then idle for 5 cycles → all outputs 0; mem_data_valid pulses are ignored and produce no array writes.
2. Miss on 0x1236, memory preloaded with mem[0x1230..0x123E] = 0xA000..0xA007 → mem_addr 0x1230, 0x1232, …, 0x123E in cycles 1–8. Array writes in cycles 5–12 with offsets 0–7 and data 0xA000–0xA007. write_tag_array in cycle 12 only; fsm_busy high in cycles 1–12.
3. miss_detected held high throughout the fill with a different address 0x4000 → ignored. A second fill of 0x4000 starts only after fsm_busy falls, in cycle 13.
4. Miss on 0xFFFE (top block) → addresses 0xFFF0–0xFFFE, no wrap into 0x0000; fill_block_addr = 0xFFF0.
5. rst asserted in cycle 7 of a fill → outputs 0 the next cycle, no tag write. A subsequent miss on 0x0020 completes normally in 12 cycles.
6. With CRITICAL_WORD_FIRST_EN, miss on 0x123C → issue order offsets 6, 7, 0, 1, 2, 3, 4, 5. crit_word_ready in cycle 5 with data 0xA006; tag write in cycle 12.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-fill logic.
//
// Contents:
//   WORDS_PER_BLOCK - 16-bit words per cache block (power of two)
//   OFFSET_BITS     - byte-offset bits within a block, log2(WORDS_PER_BLOCK*2)
//   WORD_IDX_BITS   - bits needed to index a word within a block
//   CNT_BITS        - fill counter width; one extra bit so "all issued" is
//                     distinguishable from "last word issued"
//   fill_state_t    - fill FSM states
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_IDX_BITS   = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_BITS        = WORD_IDX_BITS + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/cache_word_counter.sv
// Word counter used by the fill FSM to track issued requests and returned
// words.
//
// Parameters:
//   WIDTH    - counter width in bits (word index bits + 1)
//   TERMINAL - count value at which terminal_o is asserted
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, clears the count
//   clr_i      in   synchronous clear (wins over inc_i)
//   inc_i      in   increment by one
//   idx_o      out  low WIDTH-1 bits of the count (word index, wraps naturally)
//   terminal_o out  count equals TERMINAL
module cache_word_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-2:0] idx_o,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign idx_o      = count_q[WIDTH-2:0];
  assign terminal_o = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler in front of a pipelined, byte-addressed 16-bit memory
// with 4-cycle read latency. On a miss it issues one read per cycle for every
// word of the block, writes each returned word into the cache data array in
// order, and writes the tag array together with the last word. Because the
// memory pipelines requests, a fill takes 12 busy cycles.
//
// Optional build macro:
//   CRITICAL_WORD_FIRST_EN - fetch starts at the missed word and wraps around
//                            the block; adds output crit_word_ready, which
//                            pulses when the missed word is written.
//
// Ports:
//   clk               in   rising-edge clock
//   rst               in   synchronous active-high reset (aborts a fill)
//   miss_detected     in   lookup missed; only sampled in IDLE
//   miss_address      in   byte address of the missing access
//   fsm_busy          out  fill in progress (pipeline stall)
//   mem_enable        out  memory read request
//   mem_wr            out  memory write strobe, always 0
//   mem_addr          out  memory byte address (bit 0 always 0)
//   mem_data_valid    in   memory read data valid
//   mem_data_out      in   memory read data
//   write_data_array  out  write one word into the data array
//   write_word_offset out  word index of that write
//   write_data        out  data of that write
//   write_tag_array   out  write tag/valid for the block (last word)
//   fill_block_addr   out  base address of the block being filled
//   crit_word_ready   out  (CRITICAL_WORD_FIRST_EN only) missed word written
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int OFFSET_BITS     = cache_pkg::OFFSET_BITS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_WIDTH-1:0]              miss_address,
  output logic                               fsm_busy,
  output logic                               mem_enable,
  output logic                               mem_wr,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic                               mem_data_valid,
  input  logic [15:0]                        mem_data_out,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] write_word_offset,
  output logic [15:0]                        write_data,
  output logic                               write_tag_array,
  output logic [ADDR_WIDTH-1:0]              fill_block_addr
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                               crit_word_ready
`endif
);

  import cache_pkg::*;

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;

  // Clears the byte offset within a block, leaving tag + index bits.
  localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  fill_state_t           state_q;
  fill_state_t           state_d;
  logic [ADDR_WIDTH-1:0] fill_block_q;
  logic [ADDR_WIDTH-1:0] fill_block_d;

  logic [IDX_W-1:0]      issue_idx;
  logic [IDX_W-1:0]      ret_idx;
  logic                  issue_done;
  logic                  ret_last;
  logic                  issue_clr;
  logic                  issue_inc;
  logic                  ret_inc;
  logic                  last_beat;

  logic [IDX_W-1:0]      issue_word;
  logic [IDX_W-1:0]      ret_word;
  logic [ADDR_WIDTH-1:0] issue_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]      start_word_q;
  logic [IDX_W-1:0]      start_word_d;

  // Rotate the fetch order so the missed word comes first; the IDX_W-bit
  // add wraps within the block and never touches the tag bits.
  assign issue_word = issue_idx + start_word_q;
  assign ret_word   = ret_idx + start_word_q;
`else
  assign issue_word = issue_idx;
  assign ret_word   = ret_idx;
`endif

  assign issue_addr = fill_block_q | {{(ADDR_WIDTH-IDX_W-1){1'b0}}, issue_word, 1'b0};

  // Counter control. Both counters are held at zero in IDLE and cleared on
  // the last returned word so the next fill starts from a clean count.
  assign last_beat = (state_q == FILL) && mem_data_valid && ret_last;
  assign issue_clr = (state_q == IDLE) || last_beat;
  assign issue_inc = (state_q == FILL) && !issue_done;
  assign ret_inc   = (state_q == FILL) && mem_data_valid;

  cache_word_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (issue_clr),
    .inc_i      (issue_inc),
    .idx_o      (issue_idx),
    .terminal_o (issue_done)
  );

  cache_word_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (WORDS_PER_BLOCK - 1)
  ) u_ret_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (issue_clr),
    .inc_i      (ret_inc),
    .idx_o      (ret_idx),
    .terminal_o (ret_last)
  );

  // Next state and outputs.
  always_comb begin
    state_d           = state_q;
    fill_block_d      = fill_block_q;
`ifdef CRITICAL_WORD_FIRST_EN
    start_word_d      = start_word_q;
    crit_word_ready   = 1'b0;
`endif
    fsm_busy          = 1'b0;
    mem_enable        = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = '0;
    write_data_array  = 1'b0;
    write_word_offset = '0;
    write_data        = '0;
    write_tag_array   = 1'b0;
    fill_block_addr   = fill_block_q;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d      = FILL;
          fill_block_d = miss_address & BLOCK_MASK;
`ifdef CRITICAL_WORD_FIRST_EN
          start_word_d = miss_address[OFFSET_BITS-1:1];
`endif
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          mem_enable = 1'b1;
          mem_addr   = issue_addr;
        end
        if (mem_data_valid) begin
          write_data_array  = 1'b1;
          write_word_offset = ret_word;
          write_data        = mem_data_out;
`ifdef CRITICAL_WORD_FIRST_EN
          // The first returned word is always the missed one.
          crit_word_ready   = (ret_idx == '0);
`endif
          if (ret_last) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are forced quiet while reset is held, even mid-fill.
    if (rst) begin
      fsm_busy          = 1'b0;
      mem_enable        = 1'b0;
      mem_addr          = '0;
      write_data_array  = 1'b0;
      write_word_offset = '0;
      write_data        = '0;
      write_tag_array   = 1'b0;
      fill_block_addr   = '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_word_ready   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_block_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_word_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      fill_block_q <= fill_block_d;
`ifdef CRITICAL_WORD_FIRST_EN
      start_word_q <= start_word_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm. Contains a 4-cycle pipelined
// memory model and a cycle-timeline reference of each fill.
module tb_cache_fill_fsm;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;
  logic        write_data_array;
  logic [2:0]  write_word_offset;
  logic [15:0] write_data;
  logic        write_tag_array;
  logic [15:0] fill_block_addr;
`ifdef CRITICAL_WORD_FIRST_EN
  logic        crit_word_ready;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .mem_addr          (mem_addr),
    .mem_data_valid    (mem_data_valid),
    .mem_data_out      (mem_data_out),
    .write_data_array  (write_data_array),
    .write_word_offset (write_word_offset),
    .write_data        (write_data),
    .write_tag_array   (write_tag_array),
    .fill_block_addr   (fill_block_addr)
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    .crit_word_ready   (crit_word_ready)
`endif
  );

  // ---------------- memory model: 4-cycle pipelined read ----------------
  logic [15:0] mem [0:32767];
  logic [3:0]  pv;
  logic [15:0] pd [0:3];
  logic        inj_valid = 1'b0;
  logic [15:0] inj_data = 16'h0;

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[2:0], mem_enable};
      pd[0] <= mem[mem_addr[15:1]];
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      pd[3] <= pd[2];
    end
  end

  assign mem_data_valid = pv[3] | inj_valid;
  assign mem_data_out   = pv[3] ? pd[3] : inj_data;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, c, act, exp);
    end
  endtask

  // Word fetched n-th in a fill.
  function automatic int wi(input int sw, input int n);
    return CWF ? (sw + n) % 8 : n;
  endfunction

  task automatic check_idle(input string ctx, input int c);
    chk({ctx, ".busy"}, c, fsm_busy, 0);
    chk({ctx, ".mem_enable"}, c, mem_enable, 0);
    chk({ctx, ".mem_wr"}, c, mem_wr, 0);
    chk({ctx, ".write_data_array"}, c, write_data_array, 0);
    chk({ctx, ".write_tag_array"}, c, write_tag_array, 0);
`ifdef CRITICAL_WORD_FIRST_EN
    chk({ctx, ".crit_word_ready"}, c, crit_word_ready, 0);
`endif
  endtask

  // Runs one fill starting in the current cycle (DUT idle). Expected
  // behaviour is derived from the miss cycle: requests in cycles 1..8,
  // data in 5..12, tag in 12, idle in 13. Returns at mid-cycle 13.
  task automatic run_fill(input logic [15:0] addr, input bit hold, input logic [15:0] hold_addr,
                          input logic [15:0] exp_base, input bit has_first, input logic [15:0] first_data);
    int sw = int'(addr[3:1]);
    int base = int'(addr) & 32'hFFF0;
    int off;
    miss_detected = 1'b1;
    miss_address  = addr;
    @(posedge clk);
    #1;
    miss_detected = hold;
    miss_address  = hold_addr;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk("fill_block_addr", c, fill_block_addr, exp_base);
      chk("model_base", c, fill_block_addr, base);
      chk("busy", c, fsm_busy, (c <= 12) ? 1 : 0);
      chk("mem_enable", c, mem_enable, (c <= 8) ? 1 : 0);
      chk("mem_wr", c, mem_wr, 0);
      if (c <= 8)
        chk("mem_addr", c, mem_addr, base + 2 * wi(sw, c - 1));
      chk("write_data_array", c, write_data_array, (c >= 5 && c <= 12) ? 1 : 0);
      if (c >= 5 && c <= 12) begin
        off = wi(sw, c - 5);
        chk("write_word_offset", c, write_word_offset, off);
        chk("write_data", c, write_data, mem[(base >> 1) + off]);
        if (c == 5 && has_first)
          chk("first_word_data", c, write_data, first_data);
      end
      chk("write_tag_array", c, write_tag_array, (c == 12) ? 1 : 0);
`ifdef CRITICAL_WORD_FIRST_EN
      chk("crit_word_ready", c, crit_word_ready, (c == 5) ? 1 : 0);
`endif
      if (c < 13) begin
        @(posedge clk);
        #1;
      end
    end
    $display("fill miss=%h base=%h hold=%0d checks=%0d errors=%0d", addr, exp_base, hold, checks, errors);
  endtask

  // Idle cycles with random stray valid pulses that must be ignored.
  task automatic idle_cycles(input int n, input string ctx);
    miss_detected = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      inj_valid = 1'($urandom_range(0, 1));
      inj_data  = 16'($urandom);
      @(negedge clk);
      check_idle(ctx, i);
    end
    inj_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] addr;
    bit          hold;
    logic [15:0] hold_addr;
    logic [15:0] exp_base;
    bit          has_first;
    logic [15:0] first_data;
  } vec_t;

  vec_t vecs [0:3];

  initial begin
    // Miss on 0x1236 with a different miss held during the fill, then the
    // held 0x4000 miss is taken in cycle 13; top block; critical word case.
    vecs[0] = '{16'h1236, 1'b1, 16'h4000, 16'h1230, 1'b1, CWF ? 16'hA003 : 16'hA000};
    vecs[1] = '{16'h4000, 1'b0, 16'h0000, 16'h4000, 1'b0, 16'h0000};
    vecs[2] = '{16'hFFFE, 1'b0, 16'h0000, 16'hFFF0, 1'b0, 16'h0000};
    vecs[3] = '{16'h123C, 1'b0, 16'h0000, 16'h1230, 1'b1, CWF ? 16'hA006 : 16'hA000};
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] nxt;
    bit          h;

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int k = 0; k < 8; k++) mem[(16'h1230 >> 1) + k] = 16'hA000 + 16'(k);

    // Reset, with outputs checked while reset is held.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 0);
    chk("reset.fill_block_addr", 0, fill_block_addr, 0);
    #1;
    rst = 1'b0;
    idle_cycles(5, "post_reset_idle");
    chk("post_reset.fill_block_addr", 5, fill_block_addr, 0);

    // Table-driven fills.
    for (int v = 0; v < 4; v++)
      run_fill(vecs[v].addr, vecs[v].hold, vecs[v].hold_addr, vecs[v].exp_base,
               vecs[v].has_first, vecs[v].first_data);

    // Reset asserted in cycle 7 of a fill aborts it without a tag write.
    idle_cycles(2, "pre_abort_idle");
    miss_detected = 1'b1;
    miss_address  = 16'h2468;
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("abort.busy", c, fsm_busy, 1);
      chk("abort.mem_addr", c, mem_addr, 16'h2460 + 16'(2 * wi(4, c - 1)));
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 8; c <= 13; c++) begin
      @(negedge clk);
      check_idle("abort", c);
      chk("abort.fill_block_addr", c, fill_block_addr, 0);
      if (c < 13) begin
        @(posedge clk);
        #1;
      end
    end
    $display("abort miss=2468 at cycle 7 checks=%0d errors=%0d", checks, errors);
    run_fill(16'h0020, 1'b0, 16'h0000, 16'h0020, 1'b0, 16'h0000);

    // Randomized fills, some chained via a held miss, some with idle gaps.
    a = 16'($urandom);
    for (int t = 0; t < 25; t++) begin
      h   = 1'($urandom_range(0, 1));
      nxt = 16'($urandom);
      run_fill(a, h, nxt, a & 16'hFFF0, 1'b0, 16'h0000);
      if (h) begin
        a = nxt;
      end else begin
        idle_cycles($urandom_range(1, 3), "rand_idle");
        a = 16'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
